// File: rtl/div_dispatcher.sv
// div_dispatcher: queues unsigned operand pairs and runs them one at a time
// through an external multi-cycle divider. Results go downstream in push order.
// At most one division is in flight.
// Optional build macro DIV_ZERO_BYPASS_EN: a pair with a zero divisor skips the
// divider. It is answered directly with quotient all-ones, remainder = dividend
// and out_dbz = 1.
//
// Handshake semantics, used on both sides: a transfer happens on a rising edge
// where valid && ready. The sender holds valid and payload until that edge.
// in_ready depends only on queue occupancy, and never on a pop in the same cycle.
// out_valid is held, with outputs stable, until out_ready is seen.
module div_dispatcher #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_dividend,
  input  logic [31:0] in_divisor,
  output logic        div_start,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_quotient,
  output logic [31:0] out_remainder,
  output logic        out_dbz
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  // Current FSM state, kept as a named signal so checkers can bind to it.
  state_t state;

  // Operand-pair queue storage and bookkeeping.
  logic [31:0]    fifo_dividend [FIFO_DEPTH];
  logic [31:0]    fifo_divisor  [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [31:0] head_dividend;
  logic [31:0] head_divisor;

  assign fifo_full     = (count == FULL_COUNT);
  assign fifo_empty    = (count == '0);
  assign in_ready      = !fifo_full;
  assign push          = in_valid && !fifo_full;
  // Only the IDLE state consumes the head; an empty queue is never popped.
  assign pop           = (state == S_IDLE) && !fifo_empty;
  assign head_dividend = fifo_dividend[rd_ptr];
  assign head_divisor  = fifo_divisor[rd_ptr];

  // Queue payload write; contents need no reset because count guards reads.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dividend[wr_ptr] <= in_dividend;
      fifo_divisor[wr_ptr]  <= in_divisor;
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ONE_PTR;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ONE_PTR;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
    end
  end

  // Dispatch FSM with registered divider-side and downstream-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      div_start     <= 1'b0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_dbz       <= 1'b0;
    end else begin
      // Start is a single-cycle pulse; it is raised only on entry to START.
      div_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            // Operands stay in these registers untouched until the next pop,
            // so the divider sees them stable for the whole operation.
            div_dividend <= head_dividend;
            div_divisor  <= head_divisor;
`ifdef DIV_ZERO_BYPASS_EN
            if (head_divisor == 32'd0) begin
              out_quotient  <= 32'hFFFF_FFFF;
              out_remainder <= head_dividend;
              out_dbz       <= 1'b1;
              out_valid     <= 1'b1;
              state         <= S_OUT;
            end else begin
              div_start <= 1'b1;
              state     <= S_START;
            end
`else
            div_start <= 1'b1;
            state     <= S_START;
`endif
          end
        end
        S_START: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // div_done is only looked at here; elsewhere it is ignored.
          if (div_done) begin
            out_quotient  <= div_quotient;
            out_remainder <= div_remainder;
            out_dbz       <= (div_divisor == 32'd0);
            out_valid     <= 1'b1;
            state         <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_dispatcher.sv
// Testbench for div_dispatcher. It includes a behavioural divider with random
// latency and an expected-result queue that is filled as pairs are accepted.
// Directed cases run first, followed by a randomized traffic phase.
module tb_div_dispatcher;

  localparam int FIFO_DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_dividend;
  logic [31:0] in_divisor;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_done;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_quotient;
  logic [31:0] out_remainder;
  logic        out_dbz;

  div_dispatcher #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder),
    .out_dbz       (out_dbz)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [64:0] exp_q[$];   // {dbz, quotient, remainder}

  // divider model state
  int          starts    = 0;
  int          lat_fixed = 0;   // 0 selects a random latency of 1..4 cycles
  bit          busy      = 1'b0;
  bit          orphan    = 1'b0;
  bit          stray_en  = 1'b1;
  int          cnt       = 0;
  logic [31:0] cap_a, cap_b;

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result taken from the arithmetic definition. A zero divisor is
  // answered with all-ones and the dividend, either by the bypass or by the
  // divider model below.
  function automatic logic [64:0] ref_result(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    return {1'b0, a / b, a % b};
  endfunction

  // ---------------- behavioural divider ----------------
  initial begin
    div_done      = 1'b0;
    div_quotient  = '0;
    div_remainder = '0;
    forever begin
      @(negedge clk);
      #1;
      if (div_done) begin
        div_done = 1'b0;
        busy     = 1'b0;
        orphan   = 1'b0;
      end
      if (busy) begin
        check_eq("no_overlap_start", div_start, 1'b0);
        if (!orphan) check_eq("div_operands_stable", {1'b0, div_dividend, div_divisor}, {1'b0, cap_a, cap_b});
        cnt--;
        if (cnt <= 0) begin
          div_done      = 1'b1;
          div_quotient  = (cap_b == 0) ? 32'hFFFF_FFFF : cap_a / cap_b;
          div_remainder = (cap_b == 0) ? cap_a : cap_a % cap_b;
        end
      end else if (div_start) begin
        starts++;
        cap_a = div_dividend;
        cap_b = div_divisor;
        busy  = 1'b1;
        cnt   = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 4);
      end else if (stray_en && $urandom_range(0, 7) == 0) begin
        // Unsolicited done with junk results; it must have no effect.
        div_done      = 1'b1;
        div_quotient  = $urandom;
        div_remainder = $urandom;
      end
    end
  end

  // ---------------- output monitor ----------------
  initial begin
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_rst   = 1'b1;
    logic [64:0] prev_out   = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && !prev_rst && prev_valid && !prev_ready) begin
        check_eq("out_valid_hold", out_valid, 1'b1);
        check_eq("out_data_hold", {out_dbz, out_quotient, out_remainder}, prev_out);
      end
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_output", out_valid, 1'b0);
        else check_eq("result", {out_dbz, out_quotient, out_remainder}, exp_q.pop_front());
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_rst   = rst;
      prev_out   = {out_dbz, out_quotient, out_remainder};
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one pair for a single cycle (called at a negedge); acc reports acceptance.
  task automatic try_send(input logic [31:0] a, input logic [31:0] b, output bit acc);
    in_valid    = 1'b1;
    in_dividend = a;
    in_divisor  = b;
    acc = in_ready;
    if (acc) exp_q.push_back(ref_result(a, b));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    bit acc = 1'b0;
    int g = 0;
    do begin
      try_send(a, b, acc);
      g++;
    end while (!acc && g < 1000);
    if (!acc) check_eq("send_timeout", acc, 1'b1);
  endtask

  task automatic drain();
    int g = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [31:0] rand_divisor(input logic [31:0] a);
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return $urandom_range(1, 15);
      2:       return $urandom;
      3:       return (a == 0) ? 32'd1 : a;
      default: return $urandom_range(1, 1000);
    endcase
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    int acc_n;
    bit acc;
    logic [31:0] a, b;

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_dividend = '0;
    in_divisor  = '0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_div_start", div_start, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_quotient", out_quotient, 32'd0);
    check_eq("rst_out_remainder", out_remainder, 32'd0);
    check_eq("rst_out_dbz", out_dbz, 1'b0);
    check_eq("rst_div_dividend", div_dividend, 32'd0);
    check_eq("rst_div_divisor", div_divisor, 32'd0);

    // single pair 10/7
    out_ready = 1'b1;
    s0 = starts;
    send(32'd10, 32'd7);
    drain();
    check_eq("single_start_count", starts - s0, 1);

    // back-to-back pairs, results in order
    s0 = starts;
    send(32'd100, 32'd100);
    send(32'd100, 32'd7);
    send(32'd70, 32'd150);
    drain();
    check_eq("b2b_start_count", starts - s0, 3);

    // zero divisor
    s0 = starts;
    send(32'd100, 32'd0);
    drain();
`ifdef DIV_ZERO_BYPASS_EN
    check_eq("dbz_start_count", starts - s0, 0);
`else
    check_eq("dbz_start_count", starts - s0, 1);
`endif

    // backpressure: queue fills while downstream is stalled
    out_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      try_send(32'(i * 9 + 5), 32'd3, acc);
      acc_n += int'(acc);
    end
    repeat (20) @(negedge clk);
    check_eq("full_accepted", acc_n, FIFO_DEPTH + 1);
    check_eq("full_in_ready", in_ready, 1'b0);
    check_eq("full_out_valid", out_valid, 1'b1);
    try_send(32'd999, 32'd9, acc);
    check_eq("full_refused", acc, 1'b0);
    drain();
    check_eq("after_drain_in_ready", in_ready, 1'b1);

    // reset during WAIT with two pairs queued
    out_ready = 1'b1;
    lat_fixed = 20;
    s0 = starts;
    send(32'd1000, 32'd3);
    send(32'd2000, 32'd7);
    send(32'd3000, 32'd11);
    @(negedge clk);
    check_eq("rstmid_in_flight", busy, 1'b1);
    rst    = 1'b1;
    orphan = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstmid_out_valid", out_valid, 1'b0);
    check_eq("rstmid_div_start", div_start, 1'b0);
    check_eq("rstmid_in_ready", in_ready, 1'b1);
    begin
      int g = 0;
      while (orphan && g < 200) begin
        @(negedge clk);
        g++;
      end
      check_eq("rstmid_late_done_seen", orphan, 1'b0);
    end
    repeat (4) @(negedge clk);
    check_eq("rstmid_no_output", out_valid, 1'b0);
    check_eq("rstmid_no_restart", starts - s0, 1);
    lat_fixed = 0;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        a = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 5000));
        b = rand_divisor(a);
        try_send(a, b, acc);
      end else begin
        @(negedge clk);
      end
    end
    drain();
    check_eq("final_in_ready", in_ready, 1'b1);
    check_eq("final_out_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
